// File: rtl/m72_sdr_pkg.sv
// Shared types and constants for the SDRAM port arbiter.
// Requester indices, bus widths and the arbiter state encoding.
package m72_sdr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } sdr_arb_state_t;

  localparam int SDR_REQ_CPU  = 0;
  localparam int SDR_REQ_SND  = 1;
  localparam int SDR_REQ_LOAD = 2;

  localparam int SDR_AW = 24;
  localparam int SDR_DW = 16;

  function automatic int sdr_next_idx(
    input int idx,
    input int n
  );
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/sdr_arb_pick.sv
// Combinational winner select: first valid requester found when
// scanning upward from the start index, wrapping at N_REQ.
module sdr_arb_pick #(
  parameter int N_REQ = 3,
  parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IW-1:0]    start,
  output logic [N_REQ-1:0] grant,
  output logic             any
);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = IW'((int'(start) + off) % N_REQ);
      if (valid[idx] && !found) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign any = |valid;

endmodule

// File: rtl/sdr_port_arbiter.sv
// Shares one toggle-handshake SDRAM channel among N_REQ masters.
// Define SDR_ARB_RR_EN for round-robin; otherwise fixed priority.
module sdr_port_arbiter
  import m72_sdr_pkg::*;
#(
  parameter int N_REQ = 3
) (
  input  logic                    CLK_32M,
  input  logic                    reset_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_we,
  input  logic [2*N_REQ-1:0]      req_sel,
  input  logic [SDR_AW*N_REQ-1:0] req_addr,
  input  logic [SDR_DW*N_REQ-1:0] req_din,
  output logic [N_REQ-1:0]        req_ack,
  output logic [SDR_DW-1:0]       req_dout,
  output logic                    busy,
  output logic [SDR_AW-1:0]       sdr_addr,
  output logic [SDR_DW-1:0]       sdr_din,
  output logic [1:0]              sdr_wr_sel,
  output logic                    sdr_req,
  input  logic                    sdr_ack,
  input  logic [SDR_DW-1:0]       sdr_dout
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  sdr_arb_state_t state;

  logic [N_REQ-1:0]  gnt;
  logic [N_REQ-1:0]  gnt_q;
  logic              any;
  logic [IW-1:0]     start;
  logic              quiet;
  logic              issue;
  logic [SDR_AW-1:0] m_addr;
  logic [SDR_DW-1:0] m_din;
  logic [1:0]        m_sel;
  logic              m_we;

  assign quiet = (sdr_ack == sdr_req);
  assign issue = (state == IDLE) && quiet && any;

  sdr_arb_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .valid (req_valid),
    .start (start),
    .grant (gnt),
    .any   (any)
  );

  always_comb begin
    m_addr = '0;
    m_din  = '0;
    m_sel  = '0;
    m_we   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        m_addr = req_addr[i*SDR_AW +: SDR_AW];
        m_din  = req_din[i*SDR_DW +: SDR_DW];
        m_sel  = req_sel[i*2 +: 2];
        m_we   = req_we[i];
      end
    end
  end

`ifdef SDR_ARB_RR_EN
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] gnt_idx;

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) gnt_idx = IW'(i);
    end
  end

  // rr_ptr holds the next search start, one past the last winner
  always_ff @(posedge CLK_32M or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (issue) begin
      rr_ptr <= IW'(sdr_next_idx(int'(gnt_idx), N_REQ));
    end
  end

  assign start = rr_ptr;
`else
  assign start = '0;
`endif

  always_ff @(posedge CLK_32M or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      gnt_q      <= '0;
      sdr_req    <= 1'b0;
      sdr_wr_sel <= 2'b00;
      sdr_addr   <= '0;
      sdr_din    <= '0;
      req_dout   <= '0;
      req_ack    <= '0;
      busy       <= 1'b0;
    end else begin
      req_ack <= '0;
      unique case (state)
        IDLE: begin
          if (issue) begin
            gnt_q      <= gnt;
            sdr_addr   <= m_addr;
            sdr_din    <= m_din;
            sdr_wr_sel <= m_we ? m_sel : 2'b00;
            sdr_req    <= ~sdr_req;
            busy       <= 1'b1;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (quiet) begin
            req_dout <= sdr_dout;
            req_ack  <= gnt_q;
            state    <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdr_port_arbiter.sv
// Directed bench for sdr_port_arbiter with a toggle-protocol
// SDRAM responder and a negedge monitor for toggles and acks.
module tb_sdr_port_arbiter;
  import m72_sdr_pkg::*;

  localparam int N = 3;

  logic              CLK_32M = 1'b0;
  logic              reset_n = 1'b0;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_we;
  logic [2*N-1:0]    req_sel;
  logic [24*N-1:0]   req_addr;
  logic [16*N-1:0]   req_din;
  logic [N-1:0]      req_ack;
  logic [15:0]       req_dout;
  logic              busy;
  logic [23:0]       sdr_addr;
  logic [15:0]       sdr_din;
  logic [1:0]        sdr_wr_sel;
  logic              sdr_req;
  logic              sdr_ack = 1'b0;
  logic [15:0]       sdr_dout = 16'h0;

  always #5 CLK_32M = ~CLK_32M;

  sdr_port_arbiter #(.N_REQ(N)) dut (
    .CLK_32M    (CLK_32M),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_sel    (req_sel),
    .req_addr   (req_addr),
    .req_din    (req_din),
    .req_ack    (req_ack),
    .req_dout   (req_dout),
    .busy       (busy),
    .sdr_addr   (sdr_addr),
    .sdr_din    (sdr_din),
    .sdr_wr_sel (sdr_wr_sel),
    .sdr_req    (sdr_req),
    .sdr_ack    (sdr_ack),
    .sdr_dout   (sdr_dout)
  );

  // SDRAM controller model: acks lat cycles after a toggle
  logic        resp_en = 1'b0;
  logic        ack_ovr = 1'b0;
  int          lat     = 4;
  logic [15:0] rd_data = 16'h0;
  int          cnt     = 0;

  always @(posedge CLK_32M) begin
    if (!resp_en) begin
      sdr_ack <= ack_ovr;
      cnt     <= 0;
    end else if (sdr_req != sdr_ack) begin
      if (cnt >= lat - 1) begin
        sdr_ack  <= sdr_req;
        sdr_dout <= rd_data;
        cnt      <= 0;
      end else begin
        cnt <= cnt + 1;
      end
    end
  end

  int          n_tog = 0;
  int          n_ack = 0;
  logic        prev_req = 1'b0;
  logic [23:0] addr_log [64];

  always @(negedge CLK_32M) begin
    if (!reset_n) begin
      prev_req = sdr_req;
    end else begin
      if (sdr_req !== prev_req) begin
        addr_log[n_tog % 64] = sdr_addr;
        n_tog++;
        prev_req = sdr_req;
      end
      if (req_ack != '0) n_ack++;
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK_32M);
    #1;
  endtask

  task automatic set_req(input int i, input logic we,
                         input logic [1:0] sel,
                         input logic [23:0] addr,
                         input logic [15:0] din);
    req_we[i]          = we;
    req_sel[2*i +: 2]  = sel;
    req_addr[24*i +: 24] = addr;
    req_din[16*i +: 16]  = din;
  endtask

  task automatic wait_ack(output int idx, output int cycles,
                          output bit ok);
    ok     = 1'b0;
    idx    = -1;
    cycles = 0;
    for (int c = 1; c <= 200; c++) begin
      tick();
      if (req_ack != '0) begin
        for (int i = 0; i < N; i++) if (req_ack[i]) idx = i;
        cycles = c;
        ok     = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, cyc, t0, a0;
    bit ok;
    int exp_g [4];
`ifdef SDR_ARB_RR_EN
    exp_g = '{0, 1, 2, 0};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    req_valid = '0; req_we = '0; req_sel = '0;
    req_addr  = '0; req_din = '0;
    resp_en = 1'b1; ack_ovr = 1'b0; lat = 4;
    reset_n = 1'b0;
    repeat (3) tick();
    check("rst_ack", req_ack, 0);
    check("rst_busy", busy, 0);
    check("rst_sdr_req", sdr_req, 0);
    check("rst_wr_sel", sdr_wr_sel, 0);
    check("rst_addr", sdr_addr, 0);
    check("rst_din", sdr_din, 0);
    check("rst_dout", req_dout, 0);
    reset_n = 1'b1;
    tick();

    // single CPU read
    set_req(SDR_REQ_CPU, 1'b0, 2'b11, 24'h012345, 16'h0);
    rd_data = 16'hBEEF;
    t0 = n_tog; a0 = n_ack;
    req_valid = 3'b001;
    tick();
    check("t1_req", sdr_req, 1);
    check("t1_busy", busy, 1);
    check("t1_addr", sdr_addr, 24'h012345);
    check("t1_wr_sel", sdr_wr_sel, 0);
    wait_ack(idx, cyc, ok);
    check("t1_ack_seen", ok, 1);
    check("t1_ack_idx", idx, 0);
    check("t1_latency", cyc, 5);
    check("t1_ack_vec", req_ack, 3'b001);
    check("t1_dout", req_dout, 16'hBEEF);
    req_valid = '0;
    repeat (4) tick();
    check("t1_toggles", n_tog - t0, 1);
    check("t1_acks", n_ack - a0, 1);
    check("t1_dout_hold", req_dout, 16'hBEEF);
    check("t1_idle_busy", busy, 0);

    // sound write, valid dropped the cycle after the ack
    set_req(SDR_REQ_SND, 1'b1, 2'b10, 24'h000777, 16'h5A00);
    rd_data = 16'h1111;
    t0 = n_tog; a0 = n_ack;
    req_valid = 3'b010;
    tick();
    check("t2_issue", n_tog - t0, 1);
    check("t2_wr_sel", sdr_wr_sel, 2'b10);
    check("t2_din", sdr_din, 16'h5A00);
    check("t2_addr", sdr_addr, 24'h000777);
    wait_ack(idx, cyc, ok);
    check("t2_ack_seen", ok, 1);
    check("t2_ack_idx", idx, 1);
    check("t2_dout", req_dout, 16'h1111);
    tick();
    req_valid = '0;
    repeat (4) tick();
    check("t2_toggles", n_tog - t0, 1);
    check("t2_acks", n_ack - a0, 1);

    // held valid re-issues at k+3
    set_req(SDR_REQ_CPU, 1'b0, 2'b00, 24'h000042, 16'h0);
    rd_data = 16'h4242; lat = 2;
    t0 = n_tog;
    req_valid = 3'b001;
    wait_ack(idx, cyc, ok);
    check("t3_ack_seen", ok, 1);
    check("t3_first_tog", n_tog - t0, 1);
    tick();
    check("t3_k2_tog", n_tog - t0, 1);
    check("t3_k2_busy", busy, 0);
    tick();
    check("t3_k3_tog", n_tog - t0, 2);
    check("t3_k3_busy", busy, 1);
    req_valid = '0;
    wait_ack(idx, cyc, ok);
    check("t3_ack2_seen", ok, 1);
    check("t3_ack2_idx", idx, 0);
    repeat (3) tick();
    check("t3_toggles", n_tog - t0, 2);

    // all three requesters at once
    set_req(0, 1'b0, 2'b00, 24'h000100, 16'h0);
    set_req(1, 1'b0, 2'b00, 24'h000200, 16'h0);
    set_req(2, 1'b0, 2'b00, 24'h000300, 16'h0);
    lat = 1; rd_data = 16'h7777;
    req_valid = 3'b111;
    for (int k = 0; k < 4; k++) begin
      wait_ack(idx, cyc, ok);
      check("t4_ack_seen", ok, 1);
      check("t4_grant", idx, exp_g[k]);
    end
    req_valid = 3'b110;
    wait_ack(idx, cyc, ok);
    check("t4_grant_b", idx, 1);
    req_valid = 3'b100;
    wait_ack(idx, cyc, ok);
    check("t4_grant_c", idx, 2);
    req_valid = '0;
    repeat (3) tick();

    // reset in WAIT, then sdr_ack stuck high after release
    resp_en = 1'b0; ack_ovr = 1'b0;
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    set_req(SDR_REQ_CPU, 1'b1, 2'b01, 24'h0ABCDE, 16'h00AA);
    t0 = n_tog; a0 = n_ack;
    req_valid = 3'b001;
    repeat (3) tick();
    check("t5_wait_req", sdr_req, 1);
    check("t5_wait_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check("t5_rst_req", sdr_req, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_addr", sdr_addr, 0);
    check("t5_rst_din", sdr_din, 0);
    check("t5_rst_wr_sel", sdr_wr_sel, 0);
    check("t5_rst_dout", req_dout, 0);
    check("t5_rst_ack", req_ack, 0);
    ack_ovr = 1'b1;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (5) tick();
    check("t5_hold_req", sdr_req, 0);
    check("t5_hold_busy", busy, 0);
    check("t5_hold_tog", n_tog - t0, 1);
    check("t5_no_ack", n_ack - a0, 0);
    ack_ovr = 1'b0;
    tick();
    check("t5_settle_req", sdr_req, 0);
    tick();
    check("t5_issue_req", sdr_req, 1);
    check("t5_issue_tog", n_tog - t0, 2);
    rd_data = 16'h5555; lat = 2;
    resp_en = 1'b1;
    wait_ack(idx, cyc, ok);
    check("t5_ack_seen", ok, 1);
    check("t5_dout", req_dout, 16'h5555);
    req_valid = '0;
    repeat (3) tick();

    // back-to-back loader writes
    lat = 3;
    t0 = n_tog; a0 = n_ack;
    set_req(SDR_REQ_LOAD, 1'b1, 2'b11, 24'h100000, 16'hC000);
    req_valid = 3'b100;
    for (int k = 0; k < 4; k++) begin
      wait_ack(idx, cyc, ok);
      check("t6_ack_seen", ok, 1);
      check("t6_ack_idx", idx, 2);
      if (k < 3)
        set_req(SDR_REQ_LOAD, 1'b1, 2'b11, 24'h100000 + 24'(k + 1),
                16'hC000 + 16'(k + 1));
      else
        req_valid = '0;
    end
    repeat (4) tick();
    check("t6_toggles", n_tog - t0, 4);
    check("t6_acks", n_ack - a0, 4);
    for (int k = 0; k < 4; k++)
      check("t6_addr", addr_log[(t0 + k) % 64], 24'h100000 + 24'(k));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
